maple_frame_decoder: RTL and testbench
======================================

Name: maple_frame_decoder

Overview:
- Parametrised successor to the single-byte Maple bus bit decoder.
- Decodes the two-phase SDCKA/SDCKB data stream of one frame into DATA_W-bit words.
- Buffers decoded words in a DEPTH-entry FIFO and presents them as an AXI-Stream master with backpressure, tlast on the final word of a frame, and frame-error signalling.
- Sits between the start/end pattern detector (which drives enable) and the packet parser.

Parameters:
- DATA_W, 8: bits per output word; must be even and at least 2.
- DEPTH, 16: output FIFO entries; must be a power of two and at least 2.

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- enable  in  1  high for the duration of a frame (from pattern detector)
- sdcka_data, sdcka_posedge, sdcka_negedge  in  1 each  SDCKA level and single-cycle edge strobes
- sdckb_data, sdckb_posedge, sdckb_negedge  in  1 each  SDCKB level and single-cycle edge strobes
- m_axis_tdata  out  DATA_W  decoded word
- m_axis_tvalid  out  1  word available
- m_axis_tready  in  1  downstream accept
- m_axis_tlast  out  1  final word of frame
- m_axis_tuser  out  2  [0] partial-word error, [1] checksum error (valid only with tlast)
- overflow  out  1  sticky: a word was dropped because the FIFO was full
- frame_words  out  16  word count of the most recently completed frame

Behaviour:
- Reset: aresetn is synchronous, active-low, on aclk. All outputs reset to 0. FIFO empty, FSM in IDLE, pending register invalid.
- FSM states: IDLE, PHASE1, PHASE2, FLUSH.
  - IDLE -> PHASE1 when enable is high.
  - If sdcka_negedge is high in the same cycle as the IDLE -> PHASE1 transition, the bit is captured in that cycle.
  - PHASE1: on sdcka_negedge, shift in sdckb_data (MSB first), go to PHASE2.
  - PHASE2: on sdckb_negedge, shift in sdcka_data, go to PHASE1.
  - Any state with enable low -> FLUSH (single cycle) -> IDLE.
  - The *_posedge inputs are ignored.
- Bit counting:
  - Bit counter is ceil(log2(DATA_W)) wide.
  - When DATA_W bits have been shifted in, the word is complete and the counter wraps to 0.
  - The assembled word includes the bit captured in the completing cycle.
- Pending register:
  - A completed word is held in a pending register.
  - When a subsequent word completes, the previous pending word is pushed to the FIFO with tlast=0.
  - In FLUSH, a valid pending word is pushed with tlast=1.
  - In FLUSH, tuser[0]=1 if the bit counter is nonzero (trailing partial bits); the partial bits are discarded.
  - A frame with no complete words pushes nothing and leaves frame_words at 0.
- frame_words updates in FLUSH with the number of complete words in the frame, saturating at 16'hFFFF.
- FIFO:
  - Push and pop in the same cycle is legal, including when full.
  - Push while full with no pop: the word is dropped and overflow is set. overflow clears only on reset.
  - If the dropped word carried tlast, the tlast is lost too.
- Latency: a pushed entry drives m_axis_tvalid from the next cycle. Output data, tlast and tuser are registered and stable while tvalid=1 and tready=0.
- Reset mid-frame: discards the FIFO contents, the pending word and the partial word. The next frame starts clean.

Optional Feature:
- Macro MAPLE_FRAME_CHECKSUM_EN.
- Defined:
  - A running XOR of all complete words of the frame is kept, cleared on IDLE -> PHASE1.
  - On the tlast push, tuser[1]=1 if the XOR over all words, the last word included, is nonzero. Maple frames end with an XOR checksum word, so a correct frame gives 0.
- Undefined: tuser[1] is constant 0 and no XOR logic is present.

Decomposition:
- Package maple_pkg holds:
  - FSM state encoding: one-hot, IDLE/PHASE1/PHASE2/FLUSH.
  - tuser bit-index constants.
  - Frame word-count width constant (16).
- One sub-module, maple_sync_fifo: synchronous FIFO with DEPTH and width DATA_W+3 (data, tlast, tuser) and registered output, reused by the transmit path.

Test Plan:
- 4-word frame 0x12,0x34,0x56,0x70 with tready=1 -> four beats in order, tlast only on 0x70, tuser=0, frame_words=4.
- Same frame under MAPLE_FRAME_CHECKSUM_EN with last word 0x71 -> tuser[1]=1 on the tlast beat; with 0x70, XOR is 0 and tuser[1]=0.
- Frame of 2 words plus 3 extra bits, then enable low -> 2 beats, tlast beat has tuser[0]=1, frame_words=2.
- tready=0 while DEPTH+2 words decode -> DEPTH entries held, overflow=1; then tready=1 -> first DEPTH words delivered intact in order.
- enable rises in the same cycle as sdcka_negedge carrying bit 1 -> MSB of first word =1; aresetn low mid-word -> all outputs 0 and no stale beat on the next frame.
- DATA_W=16, DEPTH=4 build: 3-word frame -> 16-bit beats MSB first, tlast on the third word.

Source files
------------

// File: rtl/maple_pkg.sv
// Shared definitions for the Maple bus frame decoder slice: FSM state
// encoding, tuser bit positions and the frame word-count width.
package maple_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'b0001,
        ST_PHASE1 = 4'b0010,
        ST_PHASE2 = 4'b0100,
        ST_FLUSH  = 4'b1000
    } state_t;

    localparam int unsigned TUSER_PARTIAL  = 0;
    localparam int unsigned TUSER_CHECKSUM = 1;
    localparam int unsigned FRAME_CNT_W    = 16;

endpackage

// File: rtl/maple_sync_fifo.sv
// Synchronous FIFO with flop-based storage. Push and pop in the same cycle
// is accepted even when full. A push that cannot be stored raises a
// single-cycle dropped strobe. The head word is flop data gated to zero
// while the FIFO is empty.
module maple_sync_fifo #(
    parameter int unsigned WIDTH = 11,
    parameter int unsigned DEPTH = 16
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             not_empty,
    output logic             dropped
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == FULL_COUNT);
    assign not_empty = (count != '0);
    assign do_pop    = pop && not_empty;
    // When full, a simultaneous pop frees the slot the write pointer addresses.
    assign do_push   = push && (!full || do_pop);
    assign dropped   = push && full && !do_pop;
    assign head      = not_empty ? mem[rd_ptr] : '0;

    // Storage write; contents need no reset since head is gated by not_empty.
    always_ff @(posedge aclk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/maple_frame_decoder.sv
// Maple bus frame decoder: turns the two-phase SDCKA/SDCKB stream of one
// frame into DATA_W-bit words (MSB first) and streams them out over
// AXI-Stream with tlast on the final word and error flags in tuser.
// Optional build macro MAPLE_FRAME_CHECKSUM_EN adds the XOR checksum
// check reported in tuser[1].
module maple_frame_decoder
    import maple_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                   aclk,
    input  logic                   aresetn,
    input  logic                   enable,
    input  logic                   sdcka_data,
    input  logic                   sdcka_posedge,
    input  logic                   sdcka_negedge,
    input  logic                   sdckb_data,
    input  logic                   sdckb_posedge,
    input  logic                   sdckb_negedge,
    output logic [DATA_W-1:0]      m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [1:0]             m_axis_tuser,
    output logic                   overflow,
    output logic [FRAME_CNT_W-1:0] frame_words
);

    localparam int unsigned CW = $clog2(DATA_W);
    localparam int unsigned FW = DATA_W + 3;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    state_t                 state;
    state_t                 state_next;
    logic                   capture;
    logic                   cap_bit;
    logic                   start;
    logic                   flush;
    logic [CW-1:0]          bit_cnt;
    logic [DATA_W-2:0]      shreg;
    logic [DATA_W-1:0]      word;
    logic                   word_done;
    logic [DATA_W-1:0]      pending;
    logic                   pend_valid;
    logic [FRAME_CNT_W-1:0] word_cnt;
    logic                   push;
    logic [1:0]             push_user;
    logic [FW-1:0]          head;
    logic                   dropped;
    logic                   unused_posedges;

    assign unused_posedges = sdcka_posedge ^ sdckb_posedge;

    // FSM state register.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and bit-capture decode.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        cap_bit    = 1'b0;
        start      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (enable) begin
                    start      = 1'b1;
                    state_next = ST_PHASE1;
                    // A bit arriving with enable is taken now, so the PHASE1 step is already done.
                    if (sdcka_negedge) begin
                        capture    = 1'b1;
                        cap_bit    = sdckb_data;
                        state_next = ST_PHASE2;
                    end
                end
            end
            ST_PHASE1: begin
                if (!enable) begin
                    state_next = ST_FLUSH;
                end else if (sdcka_negedge) begin
                    capture    = 1'b1;
                    cap_bit    = sdckb_data;
                    state_next = ST_PHASE2;
                end
            end
            ST_PHASE2: begin
                if (!enable) begin
                    state_next = ST_FLUSH;
                end else if (sdckb_negedge) begin
                    capture    = 1'b1;
                    cap_bit    = sdcka_data;
                    state_next = ST_PHASE1;
                end
            end
            ST_FLUSH: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign flush     = (state == ST_FLUSH);
    assign word      = {shreg, cap_bit};
    assign word_done = capture && (bit_cnt == LAST_BIT);
    // The held word leaves when the next word completes, or at frame end as the last.
    assign push      = pend_valid && (word_done || flush);

    // Shift register, bit counter, pending word and frame statistics.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            shreg       <= '0;
            bit_cnt     <= '0;
            pending     <= '0;
            pend_valid  <= 1'b0;
            word_cnt    <= '0;
            frame_words <= '0;
            overflow    <= 1'b0;
        end else begin
            if (capture) begin
                shreg   <= word[DATA_W-2:0];
                bit_cnt <= word_done ? '0 : bit_cnt + 1'b1;
            end
            if (word_done) begin
                pending    <= word;
                pend_valid <= 1'b1;
                if (word_cnt != '1) begin
                    word_cnt <= word_cnt + 1'b1;
                end
            end
            if (start) begin
                word_cnt <= '0;
            end
            if (flush) begin
                bit_cnt     <= '0;
                pend_valid  <= 1'b0;
                frame_words <= word_cnt;
            end
            if (dropped) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef MAPLE_FRAME_CHECKSUM_EN
    logic [DATA_W-1:0] xor_acc;

    // Running XOR of the complete words of the current frame.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            xor_acc <= '0;
        end else if (start) begin
            xor_acc <= '0;
        end else if (word_done) begin
            xor_acc <= xor_acc ^ word;
        end
    end
`endif

    // Error flags attached to the frame-final push.
    always_comb begin
        push_user                = '0;
        push_user[TUSER_PARTIAL] = flush && (bit_cnt != '0);
`ifdef MAPLE_FRAME_CHECKSUM_EN
        push_user[TUSER_CHECKSUM] = flush && (xor_acc != '0);
`endif
    end

    maple_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .push      (push),
        .push_data ({push_user, flush, pending}),
        .pop       (m_axis_tready),
        .head      (head),
        .not_empty (m_axis_tvalid),
        .dropped   (dropped)
    );

    assign m_axis_tdata = head[DATA_W-1:0];
    assign m_axis_tlast = head[DATA_W];
    assign m_axis_tuser = head[DATA_W+2:DATA_W+1];

endmodule

// File: tb/tb_maple_frame_decoder.sv
// Self-checking bench for maple_frame_decoder: an 8-bit/16-deep instance
// driven from a frame table plus hand sequences, and a 16-bit/4-deep
// instance. Expected beats are queued as words are sent and compared as
// the DUTs emit them.
module tb_maple_frame_decoder;

`ifdef MAPLE_FRAME_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic aresetn, enable, en16;
    logic sa_d, sa_p, sa_n, sb_d, sb_p, sb_n;
    logic tready8, tready16;

    logic [7:0]  tdata8;
    logic        tvalid8, tlast8, ovf8;
    logic [1:0]  tuser8;
    logic [15:0] fw8;
    logic [15:0] tdata16;
    logic        tvalid16, tlast16, ovf16;
    logic [1:0]  tuser16;
    logic [15:0] fw16;

    maple_frame_decoder #(.DATA_W(8), .DEPTH(16)) dut8 (
        .aclk(aclk), .aresetn(aresetn), .enable(enable),
        .sdcka_data(sa_d), .sdcka_posedge(sa_p), .sdcka_negedge(sa_n),
        .sdckb_data(sb_d), .sdckb_posedge(sb_p), .sdckb_negedge(sb_n),
        .m_axis_tdata(tdata8), .m_axis_tvalid(tvalid8), .m_axis_tready(tready8),
        .m_axis_tlast(tlast8), .m_axis_tuser(tuser8),
        .overflow(ovf8), .frame_words(fw8)
    );

    maple_frame_decoder #(.DATA_W(16), .DEPTH(4)) dut16 (
        .aclk(aclk), .aresetn(aresetn), .enable(en16),
        .sdcka_data(sa_d), .sdcka_posedge(sa_p), .sdcka_negedge(sa_n),
        .sdckb_data(sb_d), .sdckb_posedge(sb_p), .sdckb_negedge(sb_n),
        .m_axis_tdata(tdata16), .m_axis_tvalid(tvalid16), .m_axis_tready(tready16),
        .m_axis_tlast(tlast16), .m_axis_tuser(tuser16),
        .overflow(ovf16), .frame_words(fw16)
    );

    typedef struct {
        logic [15:0] data;
        logic        last;
        logic [1:0]  user;
    } beat_t;

    typedef struct {
        int          n;
        logic [7:0]  w [4];
        int          extra;
        logic [7:0]  xbits;
        bit          rnd;
        logic [15:0] fw;
    } vec_t;

    beat_t exp8[$];
    beat_t exp16[$];
    int    vectors = 0;
    int    miscompares = 0;
    int    ph = 0;
    bit    rand_rdy = 1'b0;
    vec_t  tbl [6];
    logic [15:0] wa [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
        if (rand_rdy) tready8 = 1'($urandom_range(0, 1));
    endtask

    task automatic send_bit(input logic b);
        if (ph == 0) begin
            sb_d = b;
            sa_d = 1'($urandom_range(0, 1));
            sa_n = 1'b1;
        end else begin
            sa_d = b;
            sb_d = 1'($urandom_range(0, 1));
            sb_n = 1'b1;
        end
        sa_p = 1'($urandom_range(0, 1));
        sb_p = 1'($urandom_range(0, 1));
        tick();
        sa_n = 1'b0; sb_n = 1'b0; sa_p = 1'b0; sb_p = 1'b0;
        tick();
        ph ^= 1;
    endtask

    task automatic send_word(input logic [15:0] w, input int width);
        for (int i = width - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic push_exp(input bit is16, input logic [15:0] d, input logic l, input logic [1:0] u);
        beat_t b;
        b.data = d; b.last = l; b.user = u;
        if (is16) exp16.push_back(b);
        else exp8.push_back(b);
    endtask

    // Sends one frame; words with index below keep are expected at the output.
    task automatic run_frame(input bit is16, input int width, input int n, input logic [15:0] w [18],
                             input int extra, input logic [7:0] xbits, input int keep);
        logic [15:0] x;
        x = '0;
        for (int i = 0; i < n; i++) x ^= w[i];
        if (is16) en16 = 1'b1;
        else enable = 1'b1;
        ph = 0;
        tick();
        for (int i = 0; i < n; i++) begin
            send_word(w[i], width);
            if (i < keep)
                push_exp(is16, w[i], i == n - 1,
                         {(i == n - 1) && CK && (x != '0), (i == n - 1) && (extra != 0)});
        end
        for (int j = 0; j < extra; j++) send_bit(xbits[extra - 1 - j]);
        enable = 1'b0;
        en16 = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic drain();
        rand_rdy = 1'b0;
        tready8 = 1'b1;
        tready16 = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (exp8.size() == 0 && exp16.size() == 0) break;
            tick();
        end
        check("drain_q8", 64'(exp8.size()), 64'd0);
        check("drain_q16", 64'(exp16.size()), 64'd0);
        tick(); tick(); tick(); tick();
    endtask

    task automatic apply_reset();
        aresetn = 1'b0;
        enable = 1'b0;
        en16 = 1'b0;
        tick(); tick();
        check("reset_outs8", {tdata8, tvalid8, tlast8, tuser8, ovf8, fw8}, 64'd0);
        check("reset_outs16", {tdata16, tvalid16, tlast16, tuser16, ovf16, fw16}, 64'd0);
        exp8.delete();
        exp16.delete();
        aresetn = 1'b1;
        ph = 0;
        tick();
    endtask

    function automatic vec_t mk(input int n, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] c, input logic [7:0] d, input int extra,
                                input logic [7:0] xb, input bit rnd, input logic [15:0] fw);
        vec_t v;
        v.n = n;
        v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
        v.extra = extra; v.xbits = xb; v.rnd = rnd; v.fw = fw;
        return v;
    endfunction

    // Scoreboard and hold-stability checker for the 8-bit instance.
    logic        p_stall8 = 1'b0;
    logic [11:0] p_out8;
    always @(negedge aclk) begin
        beat_t e;
        if (aresetn && p_stall8)
            check("hold8", {tvalid8, tlast8, tuser8, tdata8}, p_out8);
        p_stall8 = aresetn && tvalid8 && !tready8;
        p_out8 = {tvalid8, tlast8, tuser8, tdata8};
        if (aresetn && tvalid8 && tready8) begin
            if (exp8.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL beat8: unexpected beat data=%0h last=%0b user=%0b, required none",
                         tdata8, tlast8, tuser8);
            end else begin
                e = exp8.pop_front();
                check("beat8", {tdata8, tlast8, tuser8}, {e.data[7:0], e.last, e.user});
            end
        end
    end

    // Scoreboard for the 16-bit instance.
    always @(negedge aclk) begin
        beat_t e;
        if (aresetn && tvalid16 && tready16) begin
            if (exp16.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL beat16: unexpected beat data=%0h last=%0b user=%0b, required none",
                         tdata16, tlast16, tuser16);
            end else begin
                e = exp16.pop_front();
                check("beat16", {tdata16, tlast16, tuser16}, {e.data, e.last, e.user});
            end
        end
    end

    initial begin
        #1_000_000;
        miscompares++;
        $display("FAIL timeout: simulation did not complete, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

    initial begin
        aresetn = 1'b0; enable = 1'b0; en16 = 1'b0;
        sa_d = 1'b0; sa_p = 1'b0; sa_n = 1'b0;
        sb_d = 1'b0; sb_p = 1'b0; sb_n = 1'b0;
        tready8 = 1'b1; tready16 = 1'b1;

        tbl[0] = mk(4, 8'h12, 8'h34, 8'h56, 8'h70, 0, 8'h00, 1'b0, 16'd4);
        tbl[1] = mk(4, 8'h12, 8'h34, 8'h56, 8'h71, 0, 8'h00, 1'b0, 16'd4);
        tbl[2] = mk(2, 8'hA5, 8'h3C, 8'h00, 8'h00, 3, 8'h05, 1'b0, 16'd2);
        tbl[3] = mk(4, 8'h80, 8'h01, 8'hFE, 8'h7F, 0, 8'h00, 1'b1, 16'd4);
        tbl[4] = mk(0, 8'h00, 8'h00, 8'h00, 8'h00, 5, 8'h16, 1'b0, 16'd0);
        tbl[5] = mk(1, 8'h00, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1'b0, 16'd1);

        apply_reset();

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 18; i++) wa[i] = (i < 4) ? {8'h00, tbl[v].w[i]} : 16'h0000;
            rand_rdy = tbl[v].rnd;
            tready8 = 1'b1;
            run_frame(1'b0, 8, tbl[v].n, wa, tbl[v].extra, tbl[v].xbits, tbl[v].n);
            drain();
            check("frame_words8", 64'(fw8), 64'(tbl[v].fw));
            check("overflow8_clear", 64'(ovf8), 64'd0);
        end

        // Backpressure: DEPTH+2 words with tready low; only the first DEPTH survive.
        apply_reset();
        tready8 = 1'b0;
        for (int i = 0; i < 18; i++) wa[i] = {8'h00, 8'(i * 37 + 5)};
        run_frame(1'b0, 8, 18, wa, 0, 8'h00, 16);
        check("overflow8_set", 64'(ovf8), 64'd1);
        check("frame_words8_ovf", 64'(fw8), 64'd18);
        check("tvalid8_full", 64'(tvalid8), 64'd1);
        drain();
        check("tvalid8_drained", 64'(tvalid8), 64'd0);
        check("overflow8_sticky", 64'(ovf8), 64'd1);

        // enable rises in the same cycle as the first SDCKA falling edge.
        apply_reset();
        wa[0] = 16'h009C;
        enable = 1'b1;
        sb_d = 1'b1;
        sa_d = 1'b0;
        sa_n = 1'b1;
        tick();
        sa_n = 1'b0;
        tick();
        ph = 1;
        for (int i = 6; i >= 0; i--) send_bit(wa[0][i]);
        push_exp(1'b0, 16'h009C, 1'b1, {CK, 1'b0});
        enable = 1'b0;
        tick(); tick(); tick();
        drain();
        check("frame_words8_edge", 64'(fw8), 64'd1);

        // Reset in the middle of a frame with a pending word and partial bits.
        enable = 1'b1;
        ph = 0;
        tick();
        send_word(16'h00AB, 8);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        apply_reset();
        check("post_reset_outs8", {tdata8, tvalid8, tlast8, tuser8, ovf8, fw8}, 64'd0);
        wa[0] = 16'h005A;
        run_frame(1'b0, 8, 1, wa, 0, 8'h00, 1);
        drain();
        check("frame_words8_after_reset", 64'(fw8), 64'd1);

        // Wide build: three 16-bit words.
        wa[0] = 16'hBEEF; wa[1] = 16'h1234; wa[2] = 16'h8001;
        run_frame(1'b1, 16, 3, wa, 0, 8'h00, 3);
        drain();
        check("frame_words16", 64'(fw16), 64'd3);
        check("overflow16_clear", 64'(ovf16), 64'd0);
        check("frame_words8_unchanged", 64'(fw8), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
